// File: rtl/lfsr_random_range_if.sv
// Request/result bundle for the LFSR range generator: button, gating and reseed
// controls toward the generator, drawn value and status back.
interface lfsr_random_range_if #(
  parameter int WIDTH = 8
);
  logic             bt;
  logic             enable;
  logic             timeout;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             busy;

  modport master (
    output bt, enable, timeout, seed_load, seed_in,
    input  q, valid, busy
  );

  modport slave (
    input  bt, enable, timeout, seed_load, seed_in,
    output q, valid, busy
  );
endinterface

// File: rtl/lfsr_random_range.sv
// Free-running Fibonacci LFSR with masked, bounded rejection sampling into 0..MAX_VAL.
// One draw per accepted button press; result held in q and announced by a valid strobe.
module lfsr_random_range #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
  parameter logic [WIDTH-1:0] SEED        = 8'h01,
  parameter int               MAX_VAL     = 9,
  parameter int               RETRY_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  lfsr_random_range_if.slave bus
);

  localparam int               MASK_BITS = $clog2(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MASK      = WIDTH'((1 << MASK_BITS) - 1);
  localparam logic [WIDTH-1:0] MAX_Q     = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RANGE     = WIDTH'(MAX_VAL + 1);
  localparam int               CW        = (RETRY_LIMIT > 1) ? $clog2(RETRY_LIMIT) : 1;
  localparam logic [CW-1:0]    LAST      = CW'(RETRY_LIMIT - 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] lfsr, lfsr_next, lfsr_step, cand;
  logic [WIDTH-1:0] q_r, q_next;
  logic [CW-1:0]    count, count_next;
  logic             bt_d, req;
  logic             valid_r, valid_next, busy;
  logic             hit, fallback;

  // LFSR datapath: reseed beats stepping; a zero state can never persist.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    lfsr_step = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    lfsr_next = lfsr;
    if (bus.seed_load)
      lfsr_next = (bus.seed_in == '0) ? SEED : bus.seed_in;
    else if (bus.enable)
      lfsr_next = lfsr_step;
    if (lfsr_next == '0)
      lfsr_next = SEED;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so all registers sample the same edge.
    if (reset) begin
      lfsr <= SEED;
      bt_d <= 1'b1;
    end else begin
      lfsr <= lfsr_next;
      bt_d <= bus.bt;
    end
  end

  assign req  = bt_d & ~bus.bt & bus.enable & bus.timeout & (state == IDLE) & ~bus.seed_load;
  assign cand = lfsr & MASK;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= count_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    count_next = count;
    hit        = 1'b0;
    fallback   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          next_state = DRAW;
          count_next = '0;
        end
      end
      DRAW: begin
        if (!bus.enable || bus.seed_load) begin
          next_state = IDLE;
        end else if (cand <= MAX_Q) begin
          hit        = 1'b1;
          next_state = IDLE;
        end else if (count < LAST) begin
          count_next = count + CW'(1);
        end else begin
          // cand <= MASK < 2*(MAX_VAL+1), so one subtraction lands in range.
          fallback   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM output logic
  always_comb begin
    busy       = (state == DRAW);
    valid_next = hit | fallback;
    q_next     = q_r;
    if (hit)
      q_next = cand;
    else if (fallback)
      q_next = cand - RANGE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r     <= '0;
      valid_r <= 1'b0;
    end else begin
      q_r     <= q_next;
      valid_r <= valid_next;
    end
  end

  assign bus.q     = q_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy;

endmodule

// File: doc/lfsr_random_range.md
# lfsr_random_range

Parametrised pseudo-random number generator for the game datapath: a free-running maximal-length Fibonacci LFSR draws a value in the range 0..MAX_VAL on each button press. Range reduction uses masking plus bounded rejection sampling, with a deterministic fallback. The output is held until the next press and announced by a one-cycle `valid` strobe. It supersedes the 4-bit press counter as the digit/target source feeding display and compare logic.

## Interface
- `WIDTH`, 8: LFSR and `q` width (4..16).
- `TAPS`, 8'hB8: feedback tap mask. Bit i set means state bit i enters the XOR.
- `SEED`, 8'h01: reset and zero-substitute state. Must be nonzero.
- `MAX_VAL`, 9: largest value drawn. Must be < 2^WIDTH.
- `RETRY_LIMIT`, 4: maximum DRAW cycles per request (≥1).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `bt`  in  1  press button, active-low, already debounced and synchronised.
- `enable`  in  1  block enable. Gates LFSR advance and requests.
- `timeout`  in  1  request qualifier. A press is accepted only while `timeout`=1.
- `seed_load`  in  1  synchronous reseed strobe.
- `seed_in`  in  WIDTH  reseed value.
- `q`  out  WIDTH  last drawn value, 0..MAX_VAL.
- `valid`  out  1  one-cycle strobe when `q` updates.
- `busy`  out  1  high while in DRAW.

## Operation
- **MASK** = 2^ceil(log2(MAX_VAL+1)) − 1, computed at elaboration. Defaults: MASK = 0x0F.
- **LFSR step**: fb = XOR(lfsr & TAPS); next = {lfsr[WIDTH-2:0], fb}. Default sequence from 0x01: 01, 02, 04, 08, 11, 23, 47, 8E, 1C, 38…
- **LFSR update priority**:
  1. `seed_load`=1: lfsr ← `seed_in`, or SEED if `seed_in`==0.
  2. Else if `enable`=1: step.
  3. Else: hold.
  - Lock-up guard: if lfsr is ever 0, it is forced to SEED.
- **Press detect**: `bt_d` registers `bt` every cycle. req = `bt_d` & ~`bt` & `enable` & `timeout` & (state==IDLE) & ~`seed_load`.
- **FSM states**: IDLE, DRAW.
  - IDLE → DRAW on req. retry count ← 0.
  - DRAW evaluates cand = lfsr & MASK each cycle:
    - cand ≤ MAX_VAL: q ← cand, valid ← 1, go IDLE.
    - cand > MAX_VAL and count < RETRY_LIMIT−1: count++, stay in DRAW. The LFSR has advanced, so the next cycle sees a new candidate.
    - cand > MAX_VAL and count == RETRY_LIMIT−1: q ← cand − (MAX_VAL+1), valid ← 1, go IDLE. The result is always < MAX_VAL+1 because cand ≤ MASK < 2(MAX_VAL+1).
  - DRAW with `enable`=0 or `seed_load`=1: abort to IDLE. No `valid`; `q` unchanged.
- Presses while in DRAW are ignored, not queued. A held button produces only one request, on the falling edge.
- `timeout`=0 at the press edge: the press is dropped. It is not retried when `timeout` rises.

## Timing
- **Reset values**: lfsr = SEED, `bt_d` = 1, state = IDLE, count = 0, `q` = 0, `valid` = 0, `busy` = 0. Reset mid-DRAW returns to these values immediately; no `valid` is issued.
- **Request latency**: req is registered at edge Ek. DRAW cycles follow. `q` and `valid` update at the edge closing the accepting/final DRAW cycle.
  - Latency is 1..RETRY_LIMIT cycles after Ek.
  - Worst case with defaults: 4 cycles.
- `valid` is high for exactly one cycle. `q` holds between draws.
- `busy` = (state==DRAW), registered. It is high in the cycle after Ek and falls together with the `valid` rise.
- Earliest next request: `bt_d` & ~`bt` may register at the same edge on which `valid` rises is not possible (state is still DRAW). The next request registers at the edge after that, at the earliest.

## Test plan
- **Reset**: assert `reset` asynchronously mid-cycle → `q`=0, `valid`=0, `busy`=0 immediately. Release with `enable`=1 → lfsr steps 01, 02, 04, 08, 11 on successive edges.
- **Direct accept**: `seed_load` with `seed_in`=0x11 at E0; `bt` 1→0 registered at E1 with `timeout`=1 (lfsr=0x23 in first DRAW) → at E2, `q`=3, `valid`=1 for one cycle, `busy` high only for the E1–E2 cycle.
- **Rejection**: `seed_in`=0x47 at E0; request at E1. DRAW sees 0x8E (cand 14, reject), 0x1C (12, reject), 0x38 (8, accept) → `q`=8, `valid` at E4.
- **Fallback**: same stimulus as Rejection with `RETRY_LIMIT`=2 → second DRAW cycle sees cand 12 → `q`=2 at E3.
- **Gating**: press with `timeout`=0 → no `busy`, no `valid`. Press with `enable`=0 → LFSR frozen, no draw. Drop `enable` during DRAW → abort, `q` unchanged, no `valid`. Extra press during DRAW → ignored.
- **Seeding**: `seed_in`=0 → lfsr=SEED (0x01). Hold `bt` low for 20 cycles → exactly one draw.
